// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute over one shared memory
// port, counts retired instructions and traps on illegal instructions or memory timeouts.
module multicycle_controller #(
  parameter int TIMEOUT       = 16,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              instruction,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic [2:0]               result_select,
  output logic [1:0]               PC_select,
  output logic                     ALU_select,
  output logic                     reg_write,
  output logic [2:0]               ALU_control,
  output logic                     PC_write,
  output logic                     instr_write,
  output logic                     addr_select,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic                     halted,
  output logic [1:0]               trap_cause,
  output logic [INSTRET_WIDTH-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]        WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]        WAIT_ONE    = WAIT_W'(1);
  localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = INSTRET_WIDTH'(1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH       = 3'd0,
    S_DECODE      = 3'd1,
    S_EXEC_ALU    = 3'd2,
    S_EXEC_LOAD   = 3'd3,
    S_EXEC_STORE  = 3'd4,
    S_EXEC_BRANCH = 3'd5,
    S_EXEC_JUMP   = 3'd6,
    S_TRAP        = 3'd7
  } state_t;

  state_t                   state_r, next_state_s, decode_next_s;
  logic                     in_reset_r;
  logic [1:0]               cause_r, next_cause_s;
  logic [WAIT_W-1:0]        wait_cnt_r;
  logic [INSTRET_WIDTH-1:0] instret_r;
  logic                     wait_expired_s;
  logic                     is_rtype_s, f3_known_s, f7_ok_s, alu_legal_s;
  logic [2:0]               alu_op_s;
  logic [6:0]               opcode_s, funct7_s;
  logic [2:0]               funct3_s;
  logic                     unused_instr_bits_s;

  assign opcode_s            = instruction[6:0];
  assign funct3_s            = instruction[14:12];
  assign funct7_s            = instruction[31:25];
  assign unused_instr_bits_s = ^{instruction[24:15], instruction[11:7]};
  assign wait_expired_s      = (wait_cnt_r == WAIT_LAST);
  assign trap_cause          = cause_r;
  assign instret             = instret_r;

  // Opcode dispatch out of DECODE; unsupported encodings fall through to TRAP
  always_comb begin
    decode_next_s = S_TRAP;
    case (opcode_s)
      OP_R, OP_I: decode_next_s = S_EXEC_ALU;
      OP_LOAD:    decode_next_s = (funct3_s == 3'b010) ? S_EXEC_LOAD : S_TRAP;
      OP_STORE:   decode_next_s = (funct3_s == 3'b010) ? S_EXEC_STORE : S_TRAP;
      OP_BRANCH:  decode_next_s = (funct3_s[2:1] == 2'b00) ? S_EXEC_BRANCH : S_TRAP;
      OP_JAL, OP_LUI: decode_next_s = S_EXEC_JUMP;
      OP_JALR:    decode_next_s = (funct3_s == 3'b000) ? S_EXEC_JUMP : S_TRAP;
      default:    decode_next_s = S_TRAP;
    endcase
  end

  // ALU operation and legality; sra/srai are unsupported so funct7 must be zero on shifts
  always_comb begin
    is_rtype_s = (opcode_s == OP_R);
    f3_known_s = 1'b1;
    alu_op_s   = ALU_ADD;
    case (funct3_s)
      3'b000:  alu_op_s = (is_rtype_s && funct7_s[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op_s = ALU_AND;
      3'b110:  alu_op_s = ALU_OR;
      3'b100:  alu_op_s = ALU_XOR;
      3'b010:  alu_op_s = ALU_SLT;
      3'b001:  alu_op_s = ALU_SLL;
      3'b101:  alu_op_s = ALU_SRL;
      default: f3_known_s = 1'b0;
    endcase
    if (is_rtype_s) begin
      f7_ok_s = (funct7_s == F7_ZERO) || ((funct7_s == F7_ALT) && (funct3_s == 3'b000));
    end else if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
      f7_ok_s = (funct7_s == F7_ZERO);
    end else begin
      f7_ok_s = 1'b1;
    end
    alu_legal_s = f3_known_s && f7_ok_s;
  end

  // Next state, trap cause and datapath controls; everything stays low in the post-reset cycle
  always_comb begin
    next_state_s  = state_r;
    next_cause_s  = cause_r;
    result_select = 3'd0;
    PC_select     = 2'd0;
    ALU_select    = 1'b0;
    reg_write     = 1'b0;
    ALU_control   = ALU_ADD;
    PC_write      = 1'b0;
    instr_write   = 1'b0;
    addr_select   = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    halted        = 1'b0;
    if (in_reset_r) begin
      next_state_s = S_FETCH;
      next_cause_s = CAUSE_NONE;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            instr_write  = 1'b1;
            next_state_s = S_DECODE;
          end else if (wait_expired_s) begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_TIMEOUT;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          next_state_s = decode_next_s;
          if (decode_next_s == S_TRAP) begin
            next_cause_s = CAUSE_ILLEGAL;
          end else begin
            next_cause_s = cause_r;
          end
        end
        S_EXEC_ALU: begin
          if (alu_legal_s) begin
            reg_write    = 1'b1;
            PC_write     = 1'b1;
            ALU_select   = ~is_rtype_s;
            ALU_control  = alu_op_s;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_ILLEGAL;
          end
        end
        S_EXEC_LOAD, S_EXEC_STORE: begin
          mem_req     = 1'b1;
          mem_write   = (state_r == S_EXEC_STORE);
          addr_select = 1'b1;
          ALU_select  = 1'b1;
          if (mem_ready) begin
            reg_write     = (state_r == S_EXEC_LOAD);
            result_select = (state_r == S_EXEC_LOAD) ? 3'd1 : 3'd0;
            PC_write      = 1'b1;
            next_state_s  = S_FETCH;
          end else if (wait_expired_s) begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_TIMEOUT;
          end else begin
            next_state_s = state_r;
          end
        end
        S_EXEC_BRANCH: begin
          ALU_control  = ALU_SUB;
          PC_write     = 1'b1;
          next_state_s = S_FETCH;
          if (((funct3_s == 3'b000) && zero) || ((funct3_s == 3'b001) && !zero)) begin
            PC_select = 2'd1;
          end else begin
            PC_select = 2'd0;
          end
        end
        S_EXEC_JUMP: begin
          PC_write     = 1'b1;
          reg_write    = 1'b1;
          next_state_s = S_FETCH;
          case (opcode_s)
            OP_JAL: begin
              result_select = 3'd2;
              PC_select     = 2'd1;
            end
            OP_JALR: begin
              result_select = 3'd2;
              ALU_select    = 1'b1;
              PC_select     = 2'd2;
            end
            default: begin
              result_select = 3'd3;
              PC_select     = 2'd0;
            end
          endcase
        end
        S_TRAP: begin
          halted       = 1'b1;
          next_state_s = S_TRAP;
        end
        default: begin
          next_state_s = S_TRAP;
          next_cause_s = CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  // State, trap cause and post-reset hold flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_FETCH;
      cause_r    <= CAUSE_NONE;
      in_reset_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      cause_r    <= next_cause_s;
      in_reset_r <= 1'b0;
    end
  end

  // Memory wait counter restarts whenever the state changes
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (mem_req && !mem_ready) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // One PC update per retired instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      instret_r <= {INSTRET_WIDTH{1'b0}};
    end else if (PC_write) begin
      instret_r <= instret_r + INSTRET_ONE;
    end else begin
      instret_r <= instret_r;
    end
  end

endmodule
